// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mc_state_t;

  // Younger producer (M) wins over older (W); x0 is never forwarded.
  function automatic fwd_sel_t fwd_select(
    input logic             rw_m,
    input logic [REG_W-1:0] rd_m,
    input logic             rw_w,
    input logic [REG_W-1:0] rd_w,
    input logic [REG_W-1:0] rs
  );
    if (rw_m && (rd_m != '0) && (rd_m == rs)) return FWD_MEM;
    if (rw_w && (rd_w != '0) && (rd_w == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_mc_sequencer.sv
// Fixed-latency sequencer for multi-cycle execute ops: stalls for MC_LAT
// cycles (start + MC_LAT-1 RUN cycles), then flags the result for one cycle.
module mc_sequencer
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic MultiCycleE,
  output logic mcStall,
  output logic McStartE,
  output logic McDoneE
);

  localparam int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 2);

  mc_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcStall  = 1'b0;
    McStartE = 1'b0;
    McDoneE  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MultiCycleE) begin
          mcStall  = 1'b1;
          McStartE = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = RUN;
        end
      end
      RUN: begin
        mcStall = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      // DONE ignores MultiCycleE so the finishing op cannot retrigger itself.
      DONE: begin
        McDoneE = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32 pipeline: forwarding selects,
// load-use stall, branch flush and multi-cycle execute sequencing.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MultiCycleE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             McStartE,
  output logic             McDoneE
);

  logic lw_stall;
  logic mc_stall;

  mc_sequencer #(
    .MC_LAT(MC_LAT)
  ) u_mc_seq (
    .clk        (clk),
    .reset      (reset),
    .MultiCycleE(MultiCycleE),
    .mcStall    (mc_stall),
    .McStartE   (McStartE),
    .McDoneE    (McDoneE)
  );

  assign ForwardAE = fwd_select(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
  assign ForwardBE = fwd_select(RegWriteM, RdM, RegWriteW, RdW, Rs2E);

  assign lw_stall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  assign StallF = lw_stall | mc_stall;
  assign StallD = lw_stall | mc_stall;
  assign StallE = mc_stall;
  // An op held in E by the sequencer must never be flushed or redirected.
  assign FlushD = PCSrcE & ~mc_stall;
  assign FlushE = (lw_stall | PCSrcE) & ~mc_stall;
  assign FlushM = mc_stall;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MC_LAT = 4).
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MultiCycleE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McStartE, McDoneE;
  logic [7:0] ctl;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MC_LAT(4)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .ResultSrcE0(ResultSrcE0),
    .PCSrcE     (PCSrcE),
    .MultiCycleE(MultiCycleE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushM     (FlushM),
    .McStartE   (McStartE),
    .McDoneE    (McDoneE)
  );

  // Control vector order: StallF StallD StallE FlushD FlushE FlushM McStartE McDoneE
  assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, McStartE, McDoneE};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: %b", tag, got);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0;
    PCSrcE = 1'b0; MultiCycleE = 1'b0;
  endtask

  // Move to just after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected ctl per cycle of two back-to-back multi-cycle ops plus one idle cycle.
  logic [7:0] mc_exp [11] = '{
    8'b11100110, 8'b11100100, 8'b11100100, 8'b11100100, 8'b00000001,
    8'b11100110, 8'b11100100, 8'b11100100, 8'b11100100, 8'b00000001,
    8'b00000000
  };

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #2;
    chk("reset_ctl", ctl, 8'h00);
    chk("reset_fwd", {4'b0, ForwardAE, ForwardBE}, 8'h00);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_ctl", ctl, 8'h00);

    // Forwarding priority
    RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd9;
    RegWriteM = 1'b1; RegWriteW = 1'b1;
    #1 chk("fwdA_mem_prio", {6'b0, ForwardAE}, 8'h02);
    chk("fwdB_nomatch", {6'b0, ForwardBE}, 8'h00);
    RegWriteM = 1'b0;
    #1 chk("fwdA_wb", {6'b0, ForwardAE}, 8'h01);
    RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; RegWriteM = 1'b1;
    #1 chk("fwdA_x0", {6'b0, ForwardAE}, 8'h00);
    RdM = 5'd9; RdW = 5'd9; Rs2E = 5'd9; RegWriteM = 1'b0;
    #1 chk("fwdB_wb", {6'b0, ForwardBE}, 8'h01);
    RegWriteM = 1'b1;
    #1 chk("fwdB_mem", {6'b0, ForwardBE}, 8'h02);
    chk("fwd_ctl_quiet", ctl, 8'h00);
    clear_inputs();

    // Load-use
    step();
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #1 chk("lw_rs2", ctl, 8'b11001000);
    Rs2D = 5'd3; Rs1D = 5'd7;
    #1 chk("lw_rs1", ctl, 8'b11001000);
    RdE = 5'd0; Rs1D = 5'd0;
    #1 chk("lw_x0", ctl, 8'h00);
    ResultSrcE0 = 1'b0; RdE = 5'd7; Rs1D = 5'd7;
    #1 chk("lw_not_load", ctl, 8'h00);
    clear_inputs();

    // Taken branch
    step();
    PCSrcE = 1'b1;
    #1 chk("branch", ctl, 8'b00011000);
    clear_inputs();

    // Back-to-back multi-cycle ops, branch and load-use injected during RUN
    step();
    for (int c = 1; c <= 11; c++) begin
      clear_inputs();
      MultiCycleE = (c <= 10);
      if (c == 3) PCSrcE = 1'b1;
      if (c == 2 || c == 3) begin
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
      end
      #1 chk($sformatf("mc_cycle%0d", c), ctl, mc_exp[c-1]);
      step();
    end

    // Asynchronous reset in the middle of RUN
    clear_inputs();
    MultiCycleE = 1'b1;
    #1 chk("rst_op_start", ctl, 8'b11100110);
    step();
    MultiCycleE = 1'b0;
    #1 chk("rst_op_run", ctl, 8'b11100100);
    rst_n = 1'b0;
    #1 chk("rst_async", ctl, 8'h00);
    step();
    chk("rst_held", ctl, 8'h00);
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("post_rst%0d", c), ctl, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
